// File: rtl/axis_pkt_framer.sv
// AXI-Stream packet framer: slices a raw word stream into fixed-length packets,
// prepending a header beat (magic, sequence, length) flagged with tuser.
module axis_pkt_framer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [15:0] HDR_MAGIC  = 16'hA5C3
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  input  logic                  ctrl_en,
  input  logic [7:0]            cfg_pkt_len,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [15:0]           stat_pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [7:0]            seq_q;
  logic                  slot_free_c;
  logic                  start_c;
  logic                  load_hdr_c;
  logic                  load_dat_c;
  logic                  pkt_done_c;
  logic [DATA_WIDTH-1:0] hdr_word_c;

  // Output register may be refilled when empty or being drained this cycle.
  assign slot_free_c   = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state_q == PAYLOAD) && slot_free_c;

  always_comb begin
    hdr_word_c        = '0;
    hdr_word_c[31:0]  = {HDR_MAGIC, seq_q, len_q};
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_c    = 1'b0;
    load_hdr_c = 1'b0;
    load_dat_c = 1'b0;
    pkt_done_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctrl_en && s_axis_tvalid) begin
          start_c = 1'b1;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (slot_free_c) begin
          load_hdr_c = 1'b1;
          state_d    = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (s_axis_tvalid && slot_free_c) begin
          load_dat_c = 1'b1;
          if (cnt_q == 8'd0) begin
            pkt_done_c = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Packet bookkeeping and the single output register.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      len_q         <= 8'd0;
      cnt_q         <= 8'd0;
      seq_q         <= 8'd0;
      stat_pkt_cnt  <= 16'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      if (start_c) begin
        len_q <= cfg_pkt_len;
        cnt_q <= cfg_pkt_len;
      end else if (load_dat_c) begin
        cnt_q <= cnt_q - 8'd1;
      end

      if (pkt_done_c) begin
        seq_q        <= seq_q + 8'd1;
        stat_pkt_cnt <= stat_pkt_cnt + 16'd1;
      end

      if (load_hdr_c) begin
        m_axis_tdata  <= hdr_word_c;
        m_axis_tuser  <= 1'b1;
        m_axis_tlast  <= 1'b0;
        m_axis_tvalid <= 1'b1;
      end else if (load_dat_c) begin
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tuser  <= 1'b0;
        m_axis_tlast  <= (cnt_q == 8'd0);
        m_axis_tvalid <= 1'b1;
      end else if (slot_free_c) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
